// File: rtl/voice_mixer.sv
// Voice mixer: scans NUM_CHANNELS voices once per sample_tick, reads each
// active voice's waveform LUT word and accumulates it scaled by amplitude.
// The result is then shifted, saturated and presented as one signed sample.
module voice_mixer #(
  parameter int unsigned NUM_BITS      = 32,
  parameter int unsigned NUM_CHANNELS  = 16,
  parameter int unsigned LUT_ADDR_BITS = 10,
  parameter int unsigned SAMPLE_BITS   = 16,
  parameter int unsigned AMP_BITS      = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_tick,
  input  logic [NUM_CHANNELS-1:0]            voice_active,
  input  logic [NUM_CHANNELS*AMP_BITS-1:0]   amp_in,
  input  logic [NUM_BITS-1:0]                phi_in,
  output logic [NUM_CHANNELS-1:0]            curr_note,
  output logic [NUM_CHANNELS-1:0]            acc_en,
  output logic [LUT_ADDR_BITS-1:0]           lut_addr,
  input  logic [SAMPLE_BITS-1:0]             lut_data,
  output logic [SAMPLE_BITS-1:0]             sample_out,
  output logic                               sample_valid,
  output logic                               busy,
  output logic                               tick_overrun
);

  localparam int unsigned CH_BITS   = $clog2(NUM_CHANNELS);
  localparam int unsigned PROD_BITS = SAMPLE_BITS + AMP_BITS + 1;
  localparam int unsigned SUM_BITS  = SAMPLE_BITS + AMP_BITS + CH_BITS + 1;
  localparam int unsigned PHI_LOW   = NUM_BITS - LUT_ADDR_BITS;

  localparam logic signed [SUM_BITS-1:0] SAT_MAX =
    {{(SUM_BITS-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [SUM_BITS-1:0] SAT_MIN =
    {{(SUM_BITS-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                     state;
  logic [CH_BITS-1:0]         ch;
  logic signed [SUM_BITS-1:0] sum;

  // Pipeline that tracks which voice the returning lut_data belongs to
  logic                       pipe_v1;
  logic                       pipe_v2;
  logic [CH_BITS-1:0]         ch_d1;
  logic [CH_BITS-1:0]         ch_d2;
  logic                       act_d1;
  logic                       act_d2;

  logic [AMP_BITS-1:0]         amp_sel;
  logic signed [PROD_BITS-1:0] lut_ext;
  logic signed [PROD_BITS-1:0] amp_ext;
  logic signed [PROD_BITS-1:0] prod;
  logic signed [SUM_BITS-1:0]  prod_ext;
  logic signed [SUM_BITS-1:0]  shifted;
  logic [SAMPLE_BITS-1:0]      clamped;
  logic                        unused_phi;

  // Low phase bits only matter to the phase accumulators, not to the LUT
  assign unused_phi = ^phi_in[PHI_LOW-1:0];

  // Amplitude of the voice whose LUT word is arriving this cycle
  assign amp_sel = amp_in[32'(ch_d2) * AMP_BITS +: AMP_BITS];

  // Signed sample times unsigned amplitude, widened so the product is exact
  always_comb begin
    lut_ext  = {{(PROD_BITS-SAMPLE_BITS){lut_data[SAMPLE_BITS-1]}}, lut_data};
    amp_ext  = {{(PROD_BITS-AMP_BITS){1'b0}}, amp_sel};
    prod     = lut_ext * amp_ext;
    prod_ext = {{(SUM_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
  end

  // Remove the amplitude scale and saturate to the sample range
  always_comb begin
    shifted = sum >>> AMP_BITS;
    clamped = shifted[SAMPLE_BITS-1:0];
    if (shifted > SAT_MAX) begin
      clamped = SAT_MAX[SAMPLE_BITS-1:0];
    end else if (shifted < SAT_MIN) begin
      clamped = SAT_MIN[SAMPLE_BITS-1:0];
    end
  end

  // One-hot phase read select, only while scanning
  always_comb begin
    curr_note = '0;
    if (state == SCAN) begin
      curr_note[ch] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Align voice index and enable with the one-cycle LUT read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v1 <= 1'b0;
      pipe_v2 <= 1'b0;
      ch_d1   <= '0;
      ch_d2   <= '0;
      act_d1  <= 1'b0;
      act_d2  <= 1'b0;
    end else begin
      pipe_v1 <= (state == SCAN);
      pipe_v2 <= pipe_v1;
      ch_d1   <= ch;
      ch_d2   <= ch_d1;
      act_d1  <= (state == SCAN) && voice_active[ch];
      act_d2  <= act_d1;
    end
  end

  // Frame sequencer, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      sum          <= '0;
      lut_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      acc_en       <= '0;
      tick_overrun <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      acc_en       <= '0;
      tick_overrun <= sample_tick && (state != IDLE);

      if (pipe_v2 && act_d2) begin
        sum <= sum + prod_ext;
      end

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= SCAN;
            ch    <= '0;
            sum   <= '0;
          end
        end
        SCAN: begin
          lut_addr <= phi_in[NUM_BITS-1 -: LUT_ADDR_BITS];
          if (ch == CH_BITS'(NUM_CHANNELS - 1)) begin
            state <= DRAIN;
            ch    <= '0;
          end else begin
            ch <= ch + CH_BITS'(1);
          end
        end
        DRAIN: begin
          if (ch == CH_BITS'(1)) begin
            state <= OUT;
            ch    <= '0;
          end else begin
            ch <= ch + CH_BITS'(1);
          end
        end
        OUT: begin
          sample_out   <= clamped;
          sample_valid <= 1'b1;
          acc_en       <= voice_active;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: a behavioural LUT and phase bank feed
// the DUT, a reference mix model fills a scoreboard, and a monitor compares
// every sample_valid against it.
module tb_voice_mixer;

  localparam int unsigned N   = 16;
  localparam int unsigned AB  = 8;
  localparam int unsigned SB  = 16;
  localparam int unsigned LAB = 10;

  typedef struct {
    logic [SB-1:0] sample;
    logic [N-1:0]  acc;
    int            cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              sample_tick;
  logic [N-1:0]      voice_active;
  logic [N*AB-1:0]   amp_in;
  logic [31:0]       phi_in;
  logic [N-1:0]      curr_note;
  logic [N-1:0]      acc_en;
  logic [LAB-1:0]    lut_addr;
  logic [SB-1:0]     lut_data;
  logic [SB-1:0]     sample_out;
  logic              sample_valid;
  logic              busy;
  logic              tick_overrun;

  logic signed [SB-1:0] lut_mem [1024];
  logic [31:0]          phase [N];
  logic [AB-1:0]        amp_v [N];

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   c0;

  voice_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .voice_active (voice_active),
    .amp_in       (amp_in),
    .phi_in       (phi_in),
    .curr_note    (curr_note),
    .acc_en       (acc_en),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Waveform ROM with one cycle of read latency
  always @(posedge clk) lut_data <= lut_mem[lut_addr];

  always_comb begin
    amp_in = '0;
    for (int k = 0; k < int'(N); k++) amp_in[k*AB +: AB] = amp_v[k];
  end

  always_comb begin
    phi_in = '0;
    for (int k = 0; k < int'(N); k++) if (curr_note[k]) phi_in = phase[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference mix of the current bench state
  function automatic logic [SB-1:0] model_mix();
    longint s = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (voice_active[k]) begin
        logic [31:0] p;
        p = phase[k];
        s += longint'(lut_mem[p[31:22]]) * longint'(amp_v[k]);
      end
    end
    s = s >>> AB;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return SB'(s);
  endfunction

  // Scoreboard consumer: every sample_valid must match the oldest expectation
  always @(negedge clk) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(sample_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_out", 32'(sample_out), 32'(e.sample));
        check("acc_en", 32'(acc_en), 32'(e.acc));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      if (acc_en != '0) check("acc_en_idle", 32'(acc_en), 32'd0);
    end
  end

  // Pulse sample_tick for one cycle; returns cycle index of the pulse
  task automatic pulse_tick(output int tc);
    tc = cyc;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic start_frame(output int tc);
    exp_t e;
    e.sample = model_mix();
    e.acc    = voice_active;
    e.cyc    = cyc + int'(N) + 4;
    exp_q.push_back(e);
    pulse_tick(tc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("frame_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_all(input logic [AB-1:0] a, input logic signed [SB-1:0] d);
    for (int k = 0; k < int'(N); k++) amp_v[k] = a;
    for (int i = 0; i < 1024; i++) lut_mem[i] = d;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; sample_tick = 1'b0; voice_active = '0;
    for (int k = 0; k < int'(N); k++) begin
      phase[k] = $urandom;
      amp_v[k] = '0;
    end
    for (int i = 0; i < 1024; i++) lut_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_acc_en", 32'(acc_en), 32'd0);
    check("rst_overrun", 32'(tick_overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_curr_note", 32'(curr_note), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);

    // Single voice
    set_all(8'd255, 16'sd16384);
    voice_active = 16'h0008;
    start_frame(c0);
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_drain();
    check("single_voice_value", 32'(sample_out), 32'd16320);

    // Address path: voice 5 phase drives lut_addr one cycle later
    for (int i = 0; i < 1024; i++) lut_mem[i] = SB'($urandom);
    phase[5] = 32'hA000_0000;
    voice_active = 16'h0020;
    start_frame(c0);
    for (int i = 0; i < 30 && curr_note != 16'h0020; i++) @(negedge clk);
    check("curr_note_5", 32'(curr_note), 32'h0020);
    @(negedge clk);
    check("lut_addr_5", 32'(lut_addr), 32'h280);
    wait_drain();

    // Saturation, both rails
    set_all(8'd255, 16'sd32767);
    voice_active = 16'hFFFF;
    start_frame(c0);
    wait_drain();
    check("sat_pos", 32'(sample_out), 32'h7FFF);
    set_all(8'd255, -16'sd32768);
    start_frame(c0);
    wait_drain();
    check("sat_neg", 32'(sample_out), 32'h8000);

    // Silence
    voice_active = '0;
    start_frame(c0);
    wait_drain();
    check("silence", 32'(sample_out), 32'd0);

    // Random mixes
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 1024; i++) lut_mem[i] = SB'($urandom);
      for (int k = 0; k < int'(N); k++) begin
        phase[k] = $urandom;
        amp_v[k] = AB'($urandom);
      end
      voice_active = N'($urandom);
      start_frame(c0);
      wait_drain();
    end

    // Overrun mid-frame: busy throughout, one pulse, single output
    voice_active = 16'h5A5A;
    start_frame(c0);
    while (cyc != c0 + 5) @(negedge clk);
    check("no_overrun_yet", 32'(tick_overrun), 32'd0);
    pulse_tick(c0);
    check("overrun_pulse", 32'(tick_overrun), 32'd1);
    c0 = c0 - 5;
    for (int i = 0; i < 30 && cyc < c0 + int'(N) + 4; i++) begin
      check("busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      if (cyc == c0 + 7) check("overrun_one_cycle", 32'(tick_overrun), 32'd0);
    end
    check("busy_released", 32'(busy), 32'd0);
    wait_drain();

    // Tick coincident with OUT is an overrun and starts nothing
    voice_active = 16'h0F0F;
    start_frame(c0);
    while (cyc != c0 + int'(N) + 3) @(negedge clk);
    check("out_busy", 32'(busy), 32'd1);
    pulse_tick(c0);
    check("out_overrun", 32'(tick_overrun), 32'd1);
    @(negedge clk);
    check("out_tick_ignored", 32'(busy), 32'd0);
    wait_drain();

    // Reset mid-SCAN at ch=8 abandons the frame
    voice_active = 16'hFFFF;
    pulse_tick(c0);
    while (cyc != c0 + 9) @(negedge clk);
    check("scan_ch8", 32'(curr_note), 32'h0100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_note", 32'(curr_note), 32'd0);
    check("mid_rst_lut_addr", 32'(lut_addr), 32'd0);
    check("mid_rst_sample_out", 32'(sample_out), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    repeat (25) @(negedge clk);
    start_frame(c0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, phase word width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16, voice count; power of two, at least 2.
REQ-003 SHALL have parameter LUT_ADDR_BITS, default 10, waveform LUT address width.
REQ-004 SHALL have parameter SAMPLE_BITS, default 16, signed sample width.
REQ-005 SHALL have parameter AMP_BITS, default 8, unsigned per-voice amplitude width.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-008 SHALL have port sample_tick, input, 1: one-cycle pulse starting a mix frame.
REQ-009 SHALL have port voice_active, input, NUM_CHANNELS: per-voice enable.
REQ-010 SHALL have port amp_in, input, NUM_CHANNELS*AMP_BITS: flat amplitudes; voice k occupies bits [k*AMP_BITS +: AMP_BITS].
REQ-011 SHALL have port phi_in, input, NUM_BITS: phase of the voice currently selected by curr_note.
REQ-012 SHALL have port curr_note, output, NUM_CHANNELS: one-hot phase-read select.
REQ-013 SHALL have port acc_en, output, NUM_CHANNELS: phase-advance strobes.
REQ-014 SHALL have port lut_addr, output, LUT_ADDR_BITS: registered waveform LUT address.
REQ-015 SHALL have port lut_data, input, SAMPLE_BITS: signed LUT word, valid exactly 1 cycle after lut_addr.
REQ-016 SHALL have port sample_out, output, SAMPLE_BITS: signed mixed sample.
REQ-017 SHALL have port sample_valid, output, 1: one-cycle strobe qualifying sample_out.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-019 SHALL have port tick_overrun, output, 1: one-cycle pulse flagging a sample_tick that was ignored.

Function
REQ-020 SHALL implement the FSM states IDLE, SCAN, DRAIN and OUT, with the following transitions:
- IDLE->SCAN on sample_tick; voice counter ch := 0 and sum := 0.
- SCAN lasts NUM_CHANNELS cycles, ch = 0..N-1, then ->DRAIN.
- DRAIN lasts 2 cycles, then ->OUT.
- OUT lasts 1 cycle, then ->IDLE.
REQ-021 SHALL drive curr_note combinationally to (1<<ch) in SCAN and to all-zero in every other state.
REQ-022 SHALL register lut_addr <= phi_in[NUM_BITS-1 -: LUT_ADDR_BITS] at the end of each SCAN cycle and hold it otherwise.
REQ-023 SHALL delay ch and voice_active[ch] two cycles to align with lut_data; when the delayed voice is active, sum += lut_data * amp (signed x unsigned); inactive voices add 0.
REQ-024 SHALL make sum signed, width SAMPLE_BITS+AMP_BITS+log2(NUM_CHANNELS)+1, so that it never overflows.
REQ-025 SHALL complete the final accumulation at the end of the second DRAIN cycle.
REQ-026 SHALL, in OUT, register sample_out <= clamp(sum >>> AMP_BITS, -2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1) using an arithmetic shift and saturating clamp.
REQ-027 SHALL, in OUT, also register sample_valid <= 1 and acc_en <= voice_active (phase advances after its use).
REQ-028 SHALL hold sample_valid and acc_en high for exactly one cycle per frame and at zero at all other times; sample_out holds until the next frame.
REQ-029 SHALL make total latency N+4 cycles: sample_tick in cycle T gives sample_valid in cycle T+N+4 (cycle 20 for N=16).
REQ-030 SHALL ignore a sample_tick arriving while busy and pulse tick_overrun the next cycle; a sample_tick in the same cycle as OUT is also an overrun.
REQ-031 SHALL sample voice_active and amp_in per voice during the frame; changes mid-frame affect only voices not yet accumulated.

Reset
REQ-032 SHALL, while rst is high, force state to IDLE and clear ch, sum and all delay registers.
REQ-033 SHALL reset lut_addr, sample_out, sample_valid, acc_en and tick_overrun to 0; curr_note and busy follow at 0.
REQ-034 SHALL abandon an in-progress frame on rst, with no sample_valid and no acc_en, and accept the first sample_tick after rst deasserts.

Verification
REQ-035 SHALL pass a single-voice test: voice_active=0x0008, amp[3]=255, lut_data=16384 -> sample_out=16320 with sample_valid in cycle 20 and acc_en=0x0008 in the same cycle.
REQ-036 SHALL pass an address test: phi_in=0xA0000000 while curr_note=0x0020 -> lut_addr=0x280 on the next cycle.
REQ-037 SHALL pass a saturation test: all 16 voices active, amp=255, lut_data=32767 -> sample_out=32767; lut_data=-32768 -> sample_out=-32768.
REQ-038 SHALL pass a silence test: voice_active=0 -> sample_out=0, sample_valid pulses, acc_en=0.
REQ-039 SHALL pass an overrun test: second sample_tick at cycle T+5 -> tick_overrun pulses at T+6, exactly one sample_valid, busy stays high until OUT completes.
REQ-040 SHALL pass a reset test: rst for 1 cycle at SCAN ch=8 -> no sample_valid; all outputs 0; a following sample_tick yields a correct full frame.
